// File: rtl/adc_acc_pkg.sv
`default_nettype none
//==============================================================================
// Module  : adc_acc_pkg
// Brief   : Shared state encoding, RF channel mapping and result record layout
// Revision: 1.0 - initial release
//==============================================================================
package adc_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    localparam int c_ROT_W  = 10;
    localparam int c_CHAN_W = 2;

    localparam logic [3:0] c_RF_CH0 = 4'b0001;
    localparam logic [3:0] c_RF_CH1 = 4'b0010;
    localparam logic [3:0] c_RF_CH2 = 4'b0100;
    localparam logic [3:0] c_RF_CH3 = 4'b1000;

    // Record layout, LSB first: acc | cnt | chan | rot | sat
    function automatic int rec_w(input int cnt_w, input int acc_w);
        return 1 + c_ROT_W + c_CHAN_W + cnt_w + acc_w;
    endfunction

    function automatic int off_cnt(input int acc_w);
        return acc_w;
    endfunction

    function automatic int off_chan(input int cnt_w, input int acc_w);
        return acc_w + cnt_w;
    endfunction

    function automatic int off_rot(input int cnt_w, input int acc_w);
        return acc_w + cnt_w + c_CHAN_W;
    endfunction

    function automatic int off_sat(input int cnt_w, input int acc_w);
        return acc_w + cnt_w + c_CHAN_W + c_ROT_W;
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v == c_RF_CH0) || (v == c_RF_CH1) ||
               (v == c_RF_CH2) || (v == c_RF_CH3);
    endfunction

    function automatic logic [1:0] chan_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            c_RF_CH1: idx = 2'd1;
            c_RF_CH2: idx = 2'd2;
            c_RF_CH3: idx = 2'd3;
            default:  idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
//==============================================================================
// Module  : sync_fifo
// Brief   : Single-clock show-ahead FIFO with synchronous flush
// Revision: 1.0 - initial release
//==============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    // A write into a full FIFO is allowed when the head leaves in the same cycle
    assign w_do_wr = i_wr_en & (~o_full | i_rd_en);
    assign w_do_rd = i_rd_en & ~o_empty;

    assign o_rd_data = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr && !i_flush) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/adc_window_accumulator.sv
`default_nettype none
//==============================================================================
// Module  : adc_window_accumulator
// Brief   : Sums ADC samples per adc_en window and queues tagged result records
// Revision: 1.0 - initial release
//==============================================================================
module adc_window_accumulator
    import adc_acc_pkg::*;
#(
    parameter int ADC_W      = 12,
    parameter int ACC_W      = 20,
    parameter int CNT_W      = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                fpga_clk,
    input  logic                rst_n,
    input  logic                sys_init_ctrl,
    input  logic                adc_en,
    input  logic [3:0]          rf_sw,
    input  logic [c_ROT_W-1:0]  rot_count,
    input  logic [ADC_W-1:0]    adc_data,
    input  logic                adc_valid,
    input  logic                res_ready,
    output logic                res_valid,
    output logic [ACC_W-1:0]    res_sum,
    output logic [CNT_W-1:0]    res_cnt,
    output logic [c_CHAN_W-1:0] res_chan,
    output logic [c_ROT_W-1:0]  res_rot,
    output logic                res_sat,
    output logic                ovf_err,
    output logic                sel_err
);
    localparam int c_REC_W    = rec_w(CNT_W, ACC_W);
    localparam int c_OFF_ACC  = 0;
    localparam int c_OFF_CNT  = off_cnt(ACC_W);
    localparam int c_OFF_CHAN = off_chan(CNT_W, ACC_W);
    localparam int c_OFF_ROT  = off_rot(CNT_W, ACC_W);
    localparam int c_OFF_SAT  = off_sat(CNT_W, ACC_W);

    state_t              r_state;
    logic                r_adc_en_q;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [c_CHAN_W-1:0] r_chan;
    logic [c_ROT_W-1:0]  r_rot;
    logic                r_sat;
    logic                r_ovf_err;
    logic                r_sel_err;

    logic                w_rise;
    logic                w_fall;
    logic [ACC_W:0]      w_acc_sum;
    logic                w_acc_ovf;
    logic [ACC_W-1:0]    w_acc_next;
    logic                w_cnt_max;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    logic [c_REC_W-1:0]  w_push_rec;
    logic [c_REC_W-1:0]  w_fifo_q;
    logic [c_REC_W-1:0]  w_head;

    assign w_rise = adc_en & ~r_adc_en_q;
    assign w_fall = ~adc_en & r_adc_en_q;

    assign w_acc_sum  = {1'b0, r_acc} + (ACC_W+1)'(adc_data);
    assign w_acc_ovf  = w_acc_sum[ACC_W];
    assign w_acc_next = w_acc_ovf ? '1 : w_acc_sum[ACC_W-1:0];
    assign w_cnt_max  = &r_cnt;
    assign w_cnt_next = w_cnt_max ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    assign w_push = (r_state == ST_COMMIT);
    assign w_pop  = ~w_empty & res_ready;
    assign w_drop = w_push & w_full & ~w_pop;

    always_comb begin
        w_push_rec = '0;
        w_push_rec[c_OFF_ACC  +: ACC_W]    = r_acc;
        w_push_rec[c_OFF_CNT  +: CNT_W]    = r_cnt;
        w_push_rec[c_OFF_CHAN +: c_CHAN_W] = r_chan;
        w_push_rec[c_OFF_ROT  +: c_ROT_W]  = r_rot;
        w_push_rec[c_OFF_SAT]              = r_sat;
    end

    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_adc_en_q <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_chan     <= '0;
            r_rot      <= '0;
            r_sat      <= 1'b0;
            r_ovf_err  <= 1'b0;
            r_sel_err  <= 1'b0;
        end else if (sys_init_ctrl) begin
            r_state    <= ST_IDLE;
            r_adc_en_q <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_chan     <= '0;
            r_rot      <= '0;
            r_sat      <= 1'b0;
            r_ovf_err  <= 1'b0;
            r_sel_err  <= 1'b0;
        end else begin
            r_adc_en_q <= adc_en;
            if (w_drop) r_ovf_err <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        if (is_onehot4(rf_sw)) begin
                            r_state <= ST_ACCUM;
                            r_acc   <= adc_valid ? ACC_W'(adc_data) : '0;
                            r_cnt   <= CNT_W'(adc_valid);
                            r_chan  <= chan_idx(rf_sw);
                            r_rot   <= rot_count;
                            r_sat   <= 1'b0;
                        end else begin
                            r_sel_err <= 1'b1;
                            r_state   <= ST_DISCARD;
                        end
                    end
                end
                ST_ACCUM: begin
                    // adc_en_q is always high here, so "not fall" means adc_en is high
                    if (w_fall) begin
                        r_state <= ST_COMMIT;
                    end else if (adc_valid) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
                        if (w_acc_ovf || w_cnt_max) r_sat <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                end
                ST_DISCARD: begin
                    if (w_fall) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (c_REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (fpga_clk),
        .rst_n     (rst_n),
        .i_flush   (sys_init_ctrl),
        .i_wr_en   (w_push),
        .i_wr_data (w_push_rec),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_q),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign w_head    = w_empty ? '0 : w_fifo_q;
    assign res_valid = ~w_empty;
    assign res_sum   = w_head[c_OFF_ACC  +: ACC_W];
    assign res_cnt   = w_head[c_OFF_CNT  +: CNT_W];
    assign res_chan  = w_head[c_OFF_CHAN +: c_CHAN_W];
    assign res_rot   = w_head[c_OFF_ROT  +: c_ROT_W];
    assign res_sat   = w_head[c_OFF_SAT];
    assign ovf_err   = r_ovf_err;
    assign sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_adc_window_accumulator.sv
`default_nettype none
//==============================================================================
// Module  : tb_adc_window_accumulator
// Brief   : Vector table, directed corner sequences and a randomized window model
// Revision: 1.0 - initial release
//==============================================================================
module tb_adc_window_accumulator;

    localparam int  ADC_W   = 12;
    localparam int  ACC_W   = 20;
    localparam int  CNT_W   = 10;
    localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;
    localparam int  CNT_MAX = (1 << CNT_W) - 1;

    logic             fpga_clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sys_init_ctrl = 1'b0;
    logic             adc_en = 1'b0;
    logic [3:0]       rf_sw = 4'b0001;
    logic [9:0]       rot_count = '0;
    logic [ADC_W-1:0] adc_data = '0;
    logic             adc_valid = 1'b0;
    logic             res_ready = 1'b0;

    logic             res_valid;
    logic [ACC_W-1:0] res_sum;
    logic [CNT_W-1:0] res_cnt;
    logic [1:0]       res_chan;
    logic [9:0]       res_rot;
    logic             res_sat;
    logic             ovf_err;
    logic             sel_err;

    logic             res_valid_b;
    logic [ACC_W-1:0] res_sum_b;
    logic [3:0]       res_cnt_b;
    logic [1:0]       res_chan_b;
    logic [9:0]       res_rot_b;
    logic             res_sat_b;
    logic             ovf_err_b;
    logic             sel_err_b;

    int  total = 0;
    int  bad = 0;
    bit  rand_phase = 1'b0;
    logic [63:0] exp_q[$];

    typedef struct {
        int         n;
        bit         v;
        int         d;
        logic [3:0] rf;
        int         rot;
        longint     esum;
        int         ecnt;
        int         echan;
        bit         esat;
    } vec_t;

    adc_window_accumulator #(
        .ADC_W(ADC_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .FIFO_DEPTH(8)
    ) dut (
        .fpga_clk(fpga_clk), .rst_n(rst_n), .sys_init_ctrl(sys_init_ctrl),
        .adc_en(adc_en), .rf_sw(rf_sw), .rot_count(rot_count),
        .adc_data(adc_data), .adc_valid(adc_valid), .res_ready(res_ready),
        .res_valid(res_valid), .res_sum(res_sum), .res_cnt(res_cnt),
        .res_chan(res_chan), .res_rot(res_rot), .res_sat(res_sat),
        .ovf_err(ovf_err), .sel_err(sel_err)
    );

    adc_window_accumulator #(
        .ADC_W(ADC_W), .ACC_W(ACC_W), .CNT_W(4), .FIFO_DEPTH(2)
    ) dut_c4 (
        .fpga_clk(fpga_clk), .rst_n(rst_n), .sys_init_ctrl(sys_init_ctrl),
        .adc_en(adc_en), .rf_sw(rf_sw), .rot_count(rot_count),
        .adc_data(adc_data), .adc_valid(adc_valid), .res_ready(res_ready),
        .res_valid(res_valid_b), .res_sum(res_sum_b), .res_cnt(res_cnt_b),
        .res_chan(res_chan_b), .res_rot(res_rot_b), .res_sat(res_sat_b),
        .ovf_err(ovf_err_b), .sel_err(sel_err_b)
    );

    always #5 fpga_clk = ~fpga_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // bit 63 = res_valid, then sat|rot|chan|cnt|sum in the low bits
    function automatic logic [63:0] rec(input longint sum, input int cnt,
                                        input int chan, input int rot, input bit sat);
        return {1'b1, 20'b0, sat, rot[9:0], chan[1:0], cnt[9:0], sum[19:0]};
    endfunction

    function automatic logic [63:0] head_a();
        return {res_valid, 20'b0, res_sat, res_rot, res_chan, res_cnt, res_sum};
    endfunction

    function automatic logic [63:0] head_b();
        return {res_valid_b, 20'b0, res_sat_b, res_rot_b, res_chan_b, 6'b0, res_cnt_b, res_sum_b};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge fpga_clk);
        #1;
        if (rand_phase) res_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic flush();
        sys_init_ctrl = 1'b1;
        tick();
        sys_init_ctrl = 1'b0;
    endtask

    // Drives n high cycles then one fall cycle carrying a sample that must be ignored.
    // rf_sw/rot_count wander after the rise to prove they are latched at rise.
    task automatic open_window(input int n, input bit v, input int d,
                               input logic [3:0] rf, input int rot);
        for (int i = 0; i < n; i++) begin
            adc_en    = 1'b1;
            rf_sw     = (i == 0) ? rf : ~rf;
            rot_count = 10'(rot + i);
            adc_valid = v;
            adc_data  = 12'(d);
            tick();
        end
        adc_en    = 1'b0;
        adc_valid = 1'b1;
        adc_data  = 12'd999;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic expect_pop(input string name, input logic [63:0] exp);
        check(name, head_a(), exp);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    always @(negedge fpga_clk) begin
        if (rand_phase && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rand_unexpected: got %h expected no record", head_a());
            end else begin
                check("rand_rec", head_a(), exp_q.pop_front());
            end
        end
    end

    initial begin
        vec_t tbl[5];
        tbl[0] = '{30,  1'b1, 100,  4'b0010, 5,    64'd3000,    30,  1, 1'b0};
        tbl[1] = '{300, 1'b1, 4095, 4'b0001, 7,    64'd1048575, 300, 0, 1'b1};
        tbl[2] = '{3,   1'b0, 0,    4'b1000, 9,    64'd0,       0,   3, 1'b0};
        tbl[3] = '{1,   1'b1, 55,   4'b0100, 1023, 64'd55,      1,   2, 1'b0};
        tbl[4] = '{10,  1'b1, 4095, 4'b0001, 0,    64'd40950,   10,  0, 1'b0};

        // Reset state
        tick();
        check("reset_outputs", head_a(), 64'd0);
        check("reset_flags", {62'd0, ovf_err, sel_err}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_reset_outputs", head_a(), 64'd0);

        // Table-driven windows
        for (int k = 0; k < 5; k++) begin
            open_window(tbl[k].n, tbl[k].v, tbl[k].d, tbl[k].rf, tbl[k].rot);
            check($sformatf("vec%0d_commit_cycle_valid", k), {63'd0, res_valid}, 64'd0);
            tick();
            expect_pop($sformatf("vec%0d_record", k),
                       rec(tbl[k].esum, tbl[k].ecnt, tbl[k].echan, tbl[k].rot, tbl[k].esat));
            check($sformatf("vec%0d_empty_after_pop", k), head_a(), 64'd0);
        end

        // Count saturation on the CNT_W=4 instance
        flush();
        open_window(20, 1'b1, 1, 4'b0001, 3);
        tick();
        check("cnt4_saturate", head_b(),
              {1'b1, 20'b0, 1'b1, 10'd3, 2'd0, 6'b0, 4'd15, 20'd20});

        // Overflow: nine windows into eight slots
        flush();
        res_ready = 1'b0;
        for (int r = 0; r < 9; r++) begin
            open_window(2, 1'b1, r, 4'b0001, r);
            tick();
        end
        check("ovf_set", {63'd0, ovf_err}, 64'd1);
        check("full_head", head_a(), rec(0, 2, 0, 0, 0));
        // Push into a full FIFO while the head pops in the same cycle
        open_window(2, 1'b1, 20, 4'b0010, 20);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        for (int r = 1; r < 8; r++)
            expect_pop($sformatf("drain_rot%0d", r), rec(2 * r, 2, 0, r, 0));
        expect_pop("drain_simul_push", rec(40, 2, 1, 20, 0));
        check("drain_empty", head_a(), 64'd0);

        // Flush with records queued and ovf_err set
        for (int r = 30; r < 33; r++) begin
            open_window(2, 1'b1, 1, 4'b0100, r);
            tick();
        end
        check("pre_flush_state", {62'd0, res_valid, ovf_err}, 64'd3);
        flush();
        check("flush_outputs", head_a(), 64'd0);
        check("flush_flags", {62'd0, ovf_err, sel_err}, 64'd0);

        // Non-one-hot select
        open_window(4, 1'b1, 7, 4'b0110, 11);
        tick();
        check("sel_err_set", {62'd0, res_valid, sel_err}, 64'd1);
        open_window(2, 1'b1, 8, 4'b1000, 42);
        tick();
        check("after_sel_err_chan3", head_a(), rec(16, 2, 3, 42, 0));

        // Asynchronous reset mid-window, with a record still queued
        for (int i = 0; i < 3; i++) begin
            adc_en = 1'b1; rf_sw = 4'b0001; rot_count = 10'd77;
            adc_valid = 1'b1; adc_data = 12'd5;
            tick();
        end
        adc_en = 1'b0;
        adc_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", head_a(), 64'd0);
        check("async_reset_flags", {62'd0, ovf_err, sel_err}, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("no_record_after_reset", head_a(), 64'd0);
        open_window(5, 1'b1, 9, 4'b0010, 50);
        tick();
        expect_pop("resume_after_reset", rec(45, 5, 1, 50, 0));

        // Randomized windows against the transaction-level model
        flush();
        rand_phase = 1'b1;
        for (int w = 0; w < 80; w++) begin
            int     n;
            int     k;
            int     rot;
            int     c;
            longint s;
            bit     v;
            int     d;
            n   = $urandom_range(1, 12);
            k   = $urandom_range(0, 3);
            rot = $urandom_range(0, 1023);
            s   = 0;
            c   = 0;
            for (int i = 0; i < n; i++) begin
                v = 1'($urandom_range(0, 1));
                d = $urandom_range(0, 4095);
                adc_en    = 1'b1;
                rf_sw     = (i == 0) ? 4'(1 << k) : 4'($urandom_range(0, 15));
                rot_count = (i == 0) ? 10'(rot) : 10'($urandom_range(0, 1023));
                adc_valid = v;
                adc_data  = 12'(d);
                if (v) begin
                    s += d;
                    c++;
                end
                tick();
            end
            exp_q.push_back(rec((s > ACC_MAX) ? ACC_MAX : s,
                                (c > CNT_MAX) ? CNT_MAX : c, k, rot,
                                (s > ACC_MAX) || (c > CNT_MAX)));
            adc_en    = 1'b0;
            adc_valid = 1'($urandom_range(0, 1));
            adc_data  = 12'($urandom_range(0, 4095));
            tick();
            // adc_en raised again right away must not open a window
            if ($urandom_range(0, 3) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                    adc_en    = 1'b1;
                    rf_sw     = 4'(1 << $urandom_range(0, 3));
                    adc_valid = 1'($urandom_range(0, 1));
                    adc_data  = 12'($urandom_range(0, 4095));
                    tick();
                end
            end
            adc_en    = 1'b0;
            adc_valid = 1'b0;
            tick();
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) tick();
        check("rand_drained", 64'(exp_q.size()), 64'd0);
        rand_phase = 1'b0;
        res_ready  = 1'b0;
        tick();
        check("rand_empty_end", head_a(), 64'd0);
        check("rand_no_errors", {62'd0, ovf_err, sel_err}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_window_accumulator.md
Name: adc_window_accumulator

Overview:
Downstream consumer of the rotation/measurement FSM's adc_en, rf_sw and rot_count outputs. For every adc_en-high window it accumulates the ADC samples received and tags the window with its RF channel and rotation index. It then commits one result record into a small FIFO that the host/UART readout drains with a valid/ready handshake.

Parameters:
ADC_W, 12, ADC sample width (unsigned)
ACC_W, 20, accumulator width; saturates, never wraps
CNT_W, 10, per-window sample counter width; saturates
FIFO_DEPTH, 8, result FIFO entries; power of two, minimum 2

Ports:
fpga_clk  in  1  system clock; all logic is on its rising edge
rst_n  in  1  asynchronous active-low reset
sys_init_ctrl  in  1  synchronous flush: state to IDLE, FIFO emptied, sticky flags cleared
adc_en  in  1  measurement window from the FSM; synchronous to fpga_clk
rf_sw  in  4  one-hot RF switch select from the FSM
rot_count  in  10  rotation index from the FSM
adc_data  in  ADC_W  ADC sample
adc_valid  in  1  adc_data qualifier; one sample per high cycle
res_ready  in  1  consumer ready
res_valid  out  1  FIFO non-empty
res_sum  out  ACC_W  sample sum of the window
res_cnt  out  CNT_W  number of samples in the window
res_chan  out  2  channel: 0001→0, 0010→1, 0100→2, 1000→3
res_rot  out  10  rot_count captured at window start
res_sat  out  1  this record's sum or count saturated
ovf_err  out  1  sticky: a record was dropped because the FIFO was full
sel_err  out  1  sticky: a window opened with rf_sw not one-hot

Behaviour:
- Reset (rst_n low, asynchronous) and sys_init_ctrl (synchronous) have the same effect: state IDLE, acc 0, cnt 0, adc_en_q 0, FIFO empty, res_valid 0, ovf_err 0, sel_err 0. Record outputs read 0 while the FIFO is empty.
- adc_en_q is a registered copy of adc_en. Rise = adc_en & ~adc_en_q. Fall = ~adc_en & adc_en_q.
- FSM states: IDLE, ACCUM, COMMIT, DISCARD.
- IDLE, on rise with rf_sw one-hot: go to ACCUM. acc is loaded with the rise-cycle sample (adc_data if adc_valid, else 0). cnt is loaded with adc_valid. chan and rot_count are latched.
- IDLE, on rise with rf_sw not one-hot: set sel_err and go to DISCARD.
- ACCUM, each cycle with adc_en=1 and adc_valid=1: acc += zero-extended adc_data, cnt += 1. Both saturate at all-ones. Any saturation sets the per-window sat bit.
- ACCUM, on fall: go to COMMIT. A sample arriving in the fall cycle is not counted.
- COMMIT (exactly one cycle): push {sat, rot, chan, cnt, acc} into the FIFO, then go to IDLE unconditionally. If adc_en is high again during COMMIT, no new window opens until adc_en falls and rises again.
- DISCARD: wait for fall, then go to IDLE. Nothing is pushed.
- A window with zero samples still commits, with cnt=0 and sum=0.
- Latency: fall detected in cycle t → COMMIT in t+1 → res_valid high in t+2 if the FIFO was empty.
- FIFO is show-ahead: outputs always present the head entry. Pop occurs on res_valid & res_ready.
- Push when full with no pop: the record is dropped and ovf_err is set.
- Push when full with a simultaneous pop: both happen, and nothing is dropped.
- Push and pop on an empty FIFO: push only; res_valid is 0 that cycle.
- A rf_sw change mid-window is ignored; the channel is the one latched at rise.
- Reset mid-window: the partial window is lost with no record.

Decomposition:
- Package adc_acc_pkg holds:
  - the state encoding;
  - CHAN constants for the rf_sw one-hot → index mapping;
  - the REC_W = 1+10+2+CNT_W+ACC_W record layout, with field offsets.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH):
  - single clock, rst_n async, synchronous flush input;
  - full/empty derived from pointers extended by one bit;
  - show-ahead read.

Test Plan:
- rf_sw=0010, rot_count=5, adc_en high 30 cycles, adc_valid every cycle with data=100 → one record: sum=3000, cnt=30, chan=1, rot=5, sat=0; res_valid rises 2 cycles after the fall.
- adc_data=4095 with adc_valid continuous for 300 cycles, ACC_W=20 → sum=1048575 (saturated) and sat=1. Separately with CNT_W=4, 20 samples → cnt=15 and sat=1.
- res_ready=0, 9 consecutive windows, FIFO_DEPTH=8 → 8 records held, the 9th dropped, ovf_err=1. Then res_ready=1 → 8 records drained in order of rot. Also check full + simultaneous pop/push → no drop.
- rf_sw=0110 at rise → sel_err=1 and no record. The next window with rf_sw=1000 commits chan=3 normally.
- adc_en high 3 cycles with adc_valid=0 → record with cnt=0, sum=0. Assert rst_n low mid-window → outputs 0, no record, and normal operation resumes after release.
- sys_init_ctrl pulse with 3 records queued and ovf_err set → res_valid=0 and ovf_err=0 the next cycle.
